pi_tustin_mc: RTL and testbench
===============================

Name: pi_tustin_mc

Overview:
- Time-multiplexed, multi-channel discrete PI controller using the Tustin form y[n] = y[n-1] + A·x[n] + B·x[n-1].
- Signed fixed-point arithmetic, with runtime coefficients, output clamping and anti-windup.
- Per-channel history updates only on an explicit commit, so the network solver can iterate several times within one simulation time step.
- Sits in the OPT control path beside the existing 64-bit PI, as its scalable successor for controller banks.

Parameters:
- W, 32, data width of x, y, y_max, y_min (signed, two's complement).
- COEF_W, 32, width of a_coef and b_coef (signed).
- FRAC, 16, fractional bits shared by data and coefficients (Q(W-FRAC).FRAC).
- NCH, 4, number of channels; range 1..64.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- sta, input, 1, start one evaluation of all channels; single-cycle pulse.
- commit, input, 1, copy current x/y into per-channel history (time-step advance).
- hist_clr, input, 1, zero all history registers.
- x, input, NCH*W, channel inputs; channel k occupies bits [k*W +: W].
- a_coef, input, COEF_W, A = (dt/2)·Ki + Kp.
- b_coef, input, COEF_W, B = (dt/2)·Ki − Kp.
- y_max, input, W, upper output clamp.
- y_min, input, W, lower output clamp; y_min <= y_max is required.
- y, output, NCH*W, channel outputs, packed like x.
- sat, output, NCH, per-channel flag: last evaluation was clamped.
- busy, output, 1, evaluation in progress.
- done_sig, output, 1, one-cycle pulse when all y are valid.

Behaviour:
- Reset: y=0, sat=0, busy=0, done_sig=0, all x_hist/y_hist=0, FSM to IDLE, pending flag=0.
- Reset mid-evaluation aborts it: no done_sig, partial y results are cleared.
- FSM states: IDLE, MUL, ACC, WB.
- IDLE→MUL: sta=1. x, a_coef, b_coef, y_min and y_max are latched at the same edge, so inputs may change afterwards.
- MUL (channel k): register pa = A·x_k and pb = B·x_hist_k, full width W+COEF_W.
- ACC: s = y_hist_k + (pa>>>FRAC) + (pb>>>FRAC), computed in W+COEF_W+2 bits without overflow. Shift is arithmetic truncation (see optional feature).
- WB: y_k = clamp(s, y_min, y_max); sat_k = 1 if clamped, else 0. Then k<NCH-1 → MUL with k+1; otherwise → IDLE.
- Latency: sta sampled at edge E0; WB of the last channel occurs at edge E(3·NCH). At that same edge busy falls and done_sig rises for exactly one cycle (12 cycles for NCH=4).
- busy is 1 from edge E0 until edge E(3·NCH).
- sta while busy is ignored (not queued).
- Anti-windup: y_hist receives the clamped y, so the integrator never accumulates past the limits.
- commit in IDLE (including the done_sig cycle): x_hist_k <= latched x_k and y_hist_k <= y_k for all k, at the next edge.
- commit while busy: a pending flag is set, and the commit is applied at the edge following done_sig.
- sta and commit together in IDLE: the commit is applied first, and the evaluation uses the updated history.
- hist_clr in IDLE: all histories are zeroed, with priority over commit in the same cycle. The pending flag is also cleared.
- hist_clr while busy is ignored.
- Repeated sta without commit reproduces the same result for the same x (iteration within a time step).
- The y and sat outputs hold their values between evaluations.

Optional Feature:
- Macro: PI_TUSTIN_ROUND_EN.
- Defined: each product is rounded to nearest before the shift by adding 2^(FRAC-1), with ties toward +inf.
- Undefined: plain arithmetic-shift truncation toward −inf.
- Latency is identical in both builds.

Test Plan:
- Basic step: W=32, FRAC=16, NCH=4; A=0x00010000, B=0xFFFF8000, y_min=0x80000000, y_max=0x7FFFFFFF; x0=0x00020000, other channels 0; sta → done_sig exactly 12 cycles later, y0=0x00020000, y1..y3=0, sat=0.
- Commit/advance: continue from the previous scenario; commit, then sta with the same x → y0=0x00030000. A further sta without commit → y0=0x00030000 again.
- Clamp/anti-windup: y_max=0x00028000; repeat the commit+sta cycle → y0=0x00028000 and sat[0]=1. Next commit+sta → y0 stays 0x00028000 (history never exceeds the clamp). Lowering x0 to 0xFFFF0000 → y0 drops below the limit immediately, and sat[0] returns to 0.
- Handshake corners: sta during busy → ignored, and only one done_sig is seen. commit during busy → history applied after done_sig, checked on the next evaluation. hist_clr during busy → ignored. sta+commit in the same IDLE cycle → commit is seen first. rst at cycle 5 → no done_sig, and y=0.
- Rounding: A=0x00000001, B=0, x0=0x00008000 → y0=0x00000001 with PI_TUSTIN_ROUND_EN defined, y0=0x00000000 without it.
- Negative boundary: x0=0x80000000, A=0x00010000, y_min=0xFFF00000 → y0=0xFFF00000 and sat[0]=1, with no wrap-around.

Source files
------------

// File: rtl/pi_tustin_mc.sv
// Time-multiplexed multi-channel Tustin PI controller (y += A*x + B*x_hist) with clamp, anti-windup
// and commit-gated history. Define PI_TUSTIN_ROUND_EN to round products to nearest before the shift.
module pi_tustin_mc #(
    parameter int W      = 32,
    parameter int COEF_W = 32,
    parameter int FRAC   = 16,
    parameter int NCH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sta,
    input  logic              commit,
    input  logic              hist_clr,
    input  logic [NCH*W-1:0]  x,
    input  logic [COEF_W-1:0] a_coef,
    input  logic [COEF_W-1:0] b_coef,
    input  logic [W-1:0]      y_max,
    input  logic [W-1:0]      y_min,
    output logic [NCH*W-1:0]  y,
    output logic [NCH-1:0]    sat,
    output logic              busy,
    output logic              done_sig
);
    localparam int PW = W + COEF_W;
    localparam int SW = PW + 2;
    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef PI_TUSTIN_ROUND_EN
    localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, ACC, WB} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [NCH*W-1:0]     x_lat_q, x_lat_d;
    logic [NCH*W-1:0]     x_hist_q, x_hist_d;
    logic [NCH*W-1:0]     y_hist_q, y_hist_d;
    logic [NCH*W-1:0]     y_q, y_d;
    logic [NCH-1:0]       sat_q, sat_d;
    logic [COEF_W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]         ymin_q, ymin_d, ymax_q, ymax_d;
    logic signed [PW-1:0] pa_q, pa_d, pb_q, pb_d;
    logic signed [SW-1:0] s_q, s_d;
    logic                 pend_q, pend_d;
    logic                 done_q, done_d;

    // Operands of the channel currently in the pipeline
    logic [W-1:0] x_k, xh_k, yh_k;
    always_comb begin
        x_k  = '0;
        xh_k = '0;
        yh_k = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                x_k  = x_lat_q[i*W +: W];
                xh_k = x_hist_q[i*W +: W];
                yh_k = y_hist_q[i*W +: W];
            end
        end
    end

    logic signed [PW-1:0] a_ext, b_ext, x_ext, xh_ext;
    assign a_ext  = {{W{a_q[COEF_W-1]}}, a_q};
    assign b_ext  = {{W{b_q[COEF_W-1]}}, b_q};
    assign x_ext  = {{COEF_W{x_k[W-1]}}, x_k};
    assign xh_ext = {{COEF_W{xh_k[W-1]}}, xh_k};

    // Two guard bits keep the three-term sum exact; products are sign-extended before rounding
    logic signed [SW-1:0] pa_r, pb_r, yh_ext, acc_sum;
    assign pa_r    = ($signed({{2{pa_q[PW-1]}}, pa_q}) + RND) >>> FRAC;
    assign pb_r    = ($signed({{2{pb_q[PW-1]}}, pb_q}) + RND) >>> FRAC;
    assign yh_ext  = {{(SW-W){yh_k[W-1]}}, yh_k};
    assign acc_sum = yh_ext + pa_r + pb_r;

    logic signed [SW-1:0] ymin_ext, ymax_ext;
    logic [W-1:0]         y_clamp;
    logic                 sat_clamp;
    assign ymin_ext = {{(SW-W){ymin_q[W-1]}}, ymin_q};
    assign ymax_ext = {{(SW-W){ymax_q[W-1]}}, ymax_q};

    always_comb begin
        y_clamp   = s_q[W-1:0];
        sat_clamp = 1'b0;
        if (s_q > ymax_ext) begin
            y_clamp   = ymax_q;
            sat_clamp = 1'b1;
        end else if (s_q < ymin_ext) begin
            y_clamp   = ymin_q;
            sat_clamp = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_lat_d  = x_lat_q;
        x_hist_d = x_hist_q;
        y_hist_d = y_hist_q;
        y_d      = y_q;
        sat_d    = sat_q;
        a_d      = a_q;
        b_d      = b_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        s_d      = s_q;
        pend_d   = pend_q;
        done_d   = 1'b0;

        if (state_q != IDLE && commit)
            pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                // History moves before any new evaluation latches, so sta+commit sees the new history
                if (hist_clr) begin
                    x_hist_d = '0;
                    y_hist_d = '0;
                    pend_d   = 1'b0;
                end else if (commit || pend_q) begin
                    x_hist_d = x_lat_q;
                    y_hist_d = y_q;
                    pend_d   = 1'b0;
                end
                if (sta) begin
                    x_lat_d = x;
                    a_d     = a_coef;
                    b_d     = b_coef;
                    ymin_d  = y_min;
                    ymax_d  = y_max;
                    k_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                pa_d    = a_ext * x_ext;
                pb_d    = b_ext * xh_ext;
                state_d = ACC;
            end
            ACC: begin
                s_d     = acc_sum;
                state_d = WB;
            end
            WB: begin
                for (int i = 0; i < NCH; i++) begin
                    if (k_q == KW'(i)) begin
                        y_d[i*W +: W] = y_clamp;
                        sat_d[i]      = sat_clamp;
                    end
                end
                if (k_q == KW'(NCH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            x_lat_q  <= '0;
            x_hist_q <= '0;
            y_hist_q <= '0;
            y_q      <= '0;
            sat_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            s_q      <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_lat_q  <= x_lat_d;
            x_hist_q <= x_hist_d;
            y_hist_q <= y_hist_d;
            y_q      <= y_d;
            sat_q    <= sat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            s_q      <= s_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
        end
    end

    assign y        = y_q;
    assign sat      = sat_q;
    assign busy     = (state_q != IDLE);
    assign done_sig = done_q;

endmodule

// File: tb/tb_pi_tustin_mc.sv
// Bench for pi_tustin_mc: transaction-level reference model, per-cycle compare, directed + random stimulus.
module tb_pi_tustin_mc;
    localparam int W = 32, COEF_W = 32, FRAC = 16, NCH = 4;
    localparam int LAT = 3 * NCH;

    logic              clk = 1'b0;
    logic              rst, sta, commit, hist_clr;
    logic [NCH*W-1:0]  x;
    logic [COEF_W-1:0] a_coef, b_coef;
    logic [W-1:0]      y_max, y_min;
    logic [NCH*W-1:0]  y;
    logic [NCH-1:0]    sat;
    logic              busy, done_sig;

    pi_tustin_mc #(.W(W), .COEF_W(COEF_W), .FRAC(FRAC), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .sta(sta), .commit(commit), .hist_clr(hist_clr),
        .x(x), .a_coef(a_coef), .b_coef(b_coef), .y_max(y_max), .y_min(y_min),
        .y(y), .sat(sat), .busy(busy), .done_sig(done_sig)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: whole evaluation is computed the moment sta is accepted,
    // results become visible LAT cycles later.
    int  xl_m[NCH], xh_m[NCH], yh_m[NCH], y_m[NCH], res_m[NCH];
    bit  sat_m[NCH], sres_m[NCH];
    int  a_m, b_m, ymin_m, ymax_m, cnt_m;
    bit  busy_m, done_m, pend_m;

    function automatic longint scale(input longint p);
`ifdef PI_TUSTIN_ROUND_EN
        return (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`else
        return p >>> FRAC;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        done_m = 1'b0;
        if (rst) begin
            busy_m = 0; pend_m = 0; cnt_m = 0;
            a_m = 0; b_m = 0; ymin_m = 0; ymax_m = 0;
            for (int k = 0; k < NCH; k++) begin
                xl_m[k] = 0; xh_m[k] = 0; yh_m[k] = 0; y_m[k] = 0; sat_m[k] = 0;
            end
        end else if (!busy_m) begin
            if (hist_clr) begin
                for (int k = 0; k < NCH; k++) begin xh_m[k] = 0; yh_m[k] = 0; end
                pend_m = 0;
            end else if (commit || pend_m) begin
                for (int k = 0; k < NCH; k++) begin xh_m[k] = xl_m[k]; yh_m[k] = y_m[k]; end
                pend_m = 0;
            end
            if (sta) begin
                a_m = a_coef; b_m = b_coef; ymin_m = y_min; ymax_m = y_max;
                for (int k = 0; k < NCH; k++) begin
                    longint s;
                    xl_m[k] = x[k*W +: W];
                    s = longint'(yh_m[k]) + scale(longint'(a_m) * longint'(xl_m[k]))
                        + scale(longint'(b_m) * longint'(xh_m[k]));
                    if (s > longint'(ymax_m))      begin res_m[k] = ymax_m; sres_m[k] = 1; end
                    else if (s < longint'(ymin_m)) begin res_m[k] = ymin_m; sres_m[k] = 1; end
                    else                           begin res_m[k] = int'(s); sres_m[k] = 0; end
                end
                busy_m = 1; cnt_m = 0;
            end
        end else begin
            if (commit) pend_m = 1;
            cnt_m++;
            if (cnt_m == LAT) begin
                for (int k = 0; k < NCH; k++) begin y_m[k] = res_m[k]; sat_m[k] = sres_m[k]; end
                busy_m = 0; done_m = 1;
            end
        end
    end

    // Per-cycle compare; y/sat only when no evaluation is in flight
    initial forever begin
        @(negedge clk);
        if (done_sig === 1'b1) done_cnt++;
        if (chk_en) begin
            check("busy", W'(busy), W'(busy_m));
            check("done_sig", W'(done_sig), W'(done_m));
            if (!busy_m) begin
                for (int k = 0; k < NCH; k++) begin
                    check($sformatf("y%0d", k), y[k*W +: W], y_m[k]);
                    check($sformatf("sat%0d", k), W'(sat[k]), W'(sat_m[k]));
                end
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_sig !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({nm, "_timeout"}, W'(n < 100), 32'd1);
    endtask

    // Pulses sta (plus any commit/hist_clr already raised) and checks the latency to done_sig
    task automatic run_eval(input string nm);
        int n;
        sta = 1'b1;
        @(negedge clk);
        sta = 1'b0; commit = 1'b0; hist_clr = 1'b0;
        n = 1;
        while (done_sig !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({nm, "_latency"}, n - 1, LAT);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic start_then(input int gap);
        sta = 1'b1;
        @(negedge clk);
        sta = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int d0;
        rst = 1'b1; sta = 0; commit = 0; hist_clr = 0;
        x = '0; a_coef = '0; b_coef = '0; y_max = '0; y_min = '0;
        repeat (3) @(negedge clk);
        check("rst_y", W'(y == '0), 32'd1);
        check("rst_sat", W'(sat), 32'd0);
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done_sig), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic step
        a_coef = 32'h0001_0000; b_coef = 32'hFFFF_8000;
        y_min = 32'h8000_0000; y_max = 32'h7FFF_FFFF;
        x = '0; x[31:0] = 32'h0002_0000;
        run_eval("basic");
        check("basic_y0", y[31:0], 32'h0002_0000);
        check("basic_y_rest", W'(y[NCH*W-1:W] == '0), 32'd1);
        check("basic_sat", W'(sat), 32'd0);

        // Commit / advance, then iterate without commit
        pulse_commit();
        run_eval("adv");
        check("adv_y0", y[31:0], 32'h0003_0000);
        run_eval("iter");
        check("iter_y0", y[31:0], 32'h0003_0000);

        // Clamp and anti-windup
        y_max = 32'h0002_8000;
        pulse_commit();
        run_eval("clamp");
        check("clamp_y0", y[31:0], 32'h0002_8000);
        check("clamp_sat0", W'(sat[0]), 32'd1);
        pulse_commit();
        run_eval("windup");
        check("windup_y0", y[31:0], 32'h0002_8000);
        check("windup_sat0", W'(sat[0]), 32'd1);
        x[31:0] = 32'hFFFF_0000;
        pulse_commit();
        run_eval("release");
        check("release_y0", y[31:0], 32'h0000_8000);
        check("release_sat0", W'(sat[0]), 32'd0);

        // sta while busy is dropped
        d0 = done_cnt;
        start_then(4);
        sta = 1'b1; @(negedge clk); sta = 1'b0;
        wait_done("sta_busy");
        repeat (LAT + 3) @(negedge clk);
        check("sta_busy_done_cnt", done_cnt - d0, 32'd1);
        check("sta_busy_y0", y[31:0], 32'h0000_8000);

        // commit while busy lands after done_sig
        start_then(3);
        pulse_commit();
        wait_done("pend");
        run_eval("pend_eval");
        check("pend_y0", y[31:0], 32'h0000_0000);

        // hist_clr while busy is ignored
        start_then(3);
        hist_clr = 1'b1; @(negedge clk); hist_clr = 1'b0;
        wait_done("clr_busy");
        check("clr_busy_y0", y[31:0], 32'h0000_0000);
        run_eval("clr_busy2");
        check("clr_busy2_y0", y[31:0], 32'h0000_0000);

        // sta + commit in the same idle cycle: commit first
        x[31:0] = 32'h0001_0000;
        commit = 1'b1;
        run_eval("sta_commit");
        check("sta_commit_y0", y[31:0], 32'h0001_8000);

        // hist_clr beats commit
        hist_clr = 1'b1; commit = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0; commit = 1'b0;
        run_eval("clr_idle");
        check("clr_idle_y0", y[31:0], 32'h0001_0000);

        // Reset mid-evaluation
        d0 = done_cnt;
        start_then(4);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        check("rst_mid_done_cnt", done_cnt - d0, 32'd0);
        check("rst_mid_y", W'(y == '0), 32'd1);
        check("rst_mid_busy", W'(busy), 32'd0);

        // Rounding
        a_coef = 32'h0000_0001; b_coef = '0;
        y_min = 32'h8000_0000; y_max = 32'h7FFF_FFFF;
        x = '0; x[31:0] = 32'h0000_8000;
        run_eval("round");
`ifdef PI_TUSTIN_ROUND_EN
        check("round_y0", y[31:0], 32'h0000_0001);
`else
        check("round_y0", y[31:0], 32'h0000_0000);
`endif

        // Negative boundary: most negative input clamps, no wrap
        hist_clr = 1'b1; @(negedge clk); hist_clr = 1'b0;
        a_coef = 32'h0001_0000; b_coef = '0;
        y_min = 32'hFFF0_0000; y_max = 32'h7FFF_FFFF;
        x[31:0] = 32'h8000_0000;
        run_eval("negb");
        check("negb_y0", y[31:0], 32'hFFF0_0000);
        check("negb_sat0", W'(sat[0]), 32'd1);

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            sta      = ($urandom_range(0, 7) == 0);
            commit   = ($urandom_range(0, 5) == 0);
            hist_clr = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int l1, l2, t;
                for (int k = 0; k < NCH; k++) x[k*W +: W] = $urandom;
                a_coef = $urandom_range(0, 32'h3FFFF) - 32'h1FFFF;
                b_coef = $urandom_range(0, 32'h3FFFF) - 32'h1FFFF;
                l1 = int'($urandom) >>> $urandom_range(0, 14);
                l2 = int'($urandom) >>> $urandom_range(0, 14);
                if (l1 > l2) begin t = l1; l1 = l2; l2 = t; end
                y_min = l1; y_max = l2;
            end
            @(negedge clk);
        end
        sta = 0; commit = 0; hist_clr = 0; rst = 0;
        repeat (LAT + 5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
